// File: rtl/main_mem_responder_if.sv
// Request/response bundle between a cache fill path and main_mem_responder.
interface main_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, busy
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, busy
    );
endinterface

// File: rtl/main_mem_responder.sv
// Word-wide main memory with a fixed-latency, non-stalling read return pipeline.
// Writes take effect at their edge; reads sample the array at issue and emerge LATENCY cycles later.
module main_mem_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 15,
    parameter int LATENCY    = 4     // legal range 1..8
) (
    input  logic                 clk,
    input  logic                 rst,
    main_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  rd_issue;
    logic                  wr_issue;

    logic [LATENCY-1:0]    pipe_v;
    logic [DATA_W-1:0]     pipe_d [LATENCY];

    assign idx      = bus.addr[DEPTH_LOG2:1];
    assign rd_issue = bus.enable && !bus.wr && !rst;
    assign wr_issue = bus.enable &&  bus.wr && !rst;

    // Bit 0 and any bits above the word index alias onto the same word.
    logic unused_addr_lo;
    assign unused_addr_lo = bus.addr[0];
    generate
        if (ADDR_W > DEPTH_LOG2 + 1) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.addr[ADDR_W-1:DEPTH_LOG2+1];
        end
    endgenerate

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_issue) begin
            mem[idx] <= bus.data_in;
        end
    end

    // Data registers load only alongside a valid bit, so the output stage holds
    // the last returned word while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_issue;
            if (rd_issue) begin
                pipe_d[0] <= mem[idx];
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
        end
    end

    assign bus.data_out   = pipe_d[LATENCY-1];
    assign bus.data_valid = pipe_v[LATENCY-1];
    assign bus.busy       = |pipe_v;
endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: LATENCY 1, 4 and 8 instances driven in lockstep and
// checked every cycle against a history-based model, plus a directed vector table.
module tb_main_mem_responder;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int HN = 2048;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    main_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
    main_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) b4 ();
    main_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) b8 ();

    main_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(15), .LATENCY(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    main_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(15), .LATENCY(4))
        dut4 (.clk(clk), .rst(rst), .bus(b4));
    main_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(15), .LATENCY(8))
        dut8 (.clk(clk), .rst(rst), .bus(b8));

    int total  = 0;
    int passed = 0;

    // Reference model: a log of what each edge issued, plus a sparse memory.
    int             lat [3] = '{1, 4, 8};
    logic           hist_v [HN];
    logic [DW-1:0]  hist_d [HN];
    logic [DW-1:0]  mem_m [int];
    int             k = 0;
    int             last_rst = -1;
    logic           ev [3];
    logic [DW-1:0]  eo [3];
    logic           eb [3];
    int             vcount4 = 0;

    typedef struct {
        logic          r;
        logic          en;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          exp_v;
        logic [DW-1:0] exp_d;
        logic          exp_b;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, k);
        else passed++;
    endtask

    task automatic model_edge(input logic r, input logic en, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        int idx;
        int j;
        idx = int'(a[15:1]);
        if (k >= HN) begin
            $display("FAIL history_bound: got %0d expected < %0d", k, HN);
            $fatal(1);
        end
        hist_v[k] = !r && en && !w;
        hist_d[k] = (hist_v[k] && mem_m.exists(idx)) ? mem_m[idx] : 'x;
        if (!r && en && w) mem_m[idx] = d;
        if (r) last_rst = k;
        for (int l = 0; l < 3; l++) begin
            j = k - lat[l] + 1;
            ev[l] = 1'b0;
            if (j > last_rst && j >= 0) ev[l] = hist_v[j];
            if (r) eo[l] = '0;
            else if (ev[l]) eo[l] = hist_d[j];
            eb[l] = 1'b0;
            for (int m = j; m <= k; m++)
                if (m > last_rst && m >= 0 && hist_v[m]) eb[l] = 1'b1;
        end
        k++;
    endtask

    task automatic step(input logic r, input logic en, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic          dv [3];
        logic [DW-1:0] dd [3];
        logic          db [3];
        rst = r;
        b1.enable = en; b1.wr = w; b1.addr = a; b1.data_in = d;
        b4.enable = en; b4.wr = w; b4.addr = a; b4.data_in = d;
        b8.enable = en; b8.wr = w; b8.addr = a; b8.data_in = d;
        @(posedge clk);
        model_edge(r, en, w, a, d);
        #1;
        dv[0] = b1.data_valid; dd[0] = b1.data_out; db[0] = b1.busy;
        dv[1] = b4.data_valid; dd[1] = b4.data_out; db[1] = b4.busy;
        dv[2] = b8.data_valid; dd[2] = b8.data_out; db[2] = b8.busy;
        if (dv[1] === 1'b1) vcount4++;
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("L%0d data_valid", lat[l]), 32'(dv[l]), 32'(ev[l]));
            chk($sformatf("L%0d data_out",   lat[l]), 32'(dd[l]), 32'(eo[l]));
            chk($sformatf("L%0d busy",       lat[l]), 32'(db[l]), 32'(eb[l]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'hxxxx, 16'hxxxx);
    endtask

    initial begin
        int vc;
        logic [AW-1:0] ra;

        // Expected outputs are for the LATENCY=4 instance, seen after each row's edge.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h0042, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 16'h0000, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0043, 16'h0000, 1'b0, 16'h0000, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hBEEF, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hBEEF, 1'b0};

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].r, tbl[i].en, tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d valid", i), 32'(b4.data_valid), 32'(tbl[i].exp_v));
            chk($sformatf("tbl%0d data",  i), 32'(b4.data_out),   32'(tbl[i].exp_d));
            chk($sformatf("tbl%0d busy",  i), 32'(b4.busy),       32'(tbl[i].exp_b));
        end

        // Block fill: 8 back-to-back reads stream back with no gaps.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 16'h1230 + 16'(2*i), 16'(i));
        vc = vcount4;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h1230 + 16'(2*i), 16'h0);
        idle(10);
        chk("fill valid count", 32'(vcount4 - vc), 32'd8);

        // Hazard: read old, overwrite, read new.
        step(1'b0, 1'b1, 1'b1, 16'h0010, 16'h1111);
        vc = vcount4;
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0010, 16'h2222);
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        idle(10);
        chk("hazard valid count", 32'(vcount4 - vc), 32'd2);

        // Reset with reads in flight; a write during reset must be ignored too.
        vc = vcount4;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h1230 + 16'(2*i), 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h0042, 16'hDEAD);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0);
        idle(10);
        chk("flushed reads", 32'(vcount4 - vc), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0042, 16'h0);
        idle(9);

        // Randomized traffic over a preloaded pool of 16 words.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 16'(2*i), 16'($urandom));
        for (int i = 0; i < 500; i++) begin
            ra = 16'({$urandom_range(15, 0), 1'b0}) | 16'($urandom_range(1, 0));
            step(($urandom_range(59, 0) == 0), ($urandom_range(3, 0) != 0),
                 ($urandom_range(2, 0) == 0), ra, 16'($urandom));
        end
        idle(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
